// File: rtl/qspi_target.sv
// qspi_target: mode-0 SPI/QSPI responder streaming bytes into and out of a 16x8 register file.
// Ports: clk/rst_n system clock and asynchronous active-low reset; qspi_sck_i/qspi_csn_i/
// qspi_dq*_i initiator pins; qspi_dq*_o/qspi_dq*_en data outputs and per-lane drive enables;
// reg_rd_addr/reg_rd_dat host-side register read; wr_evt/wr_addr/wr_dat one-cycle report
// per byte written over SPI; busy high while a transaction is in progress.
module qspi_target #(
  parameter int unsigned DUMMY_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       qspi_sck_i,
  input  logic       qspi_csn_i,
  input  logic       qspi_dq0_i,
  input  logic       qspi_dq1_i,
  input  logic       qspi_dq2_i,
  input  logic       qspi_dq3_i,
  output logic       qspi_dq0_o,
  output logic       qspi_dq1_o,
  output logic       qspi_dq2_o,
  output logic       qspi_dq3_o,
  output logic       qspi_dq0_en,
  output logic       qspi_dq1_en,
  output logic       qspi_dq2_en,
  output logic       qspi_dq3_en,
  input  logic [3:0] reg_rd_addr,
  output logic [7:0] reg_rd_dat,
  output logic       wr_evt,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_dat,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, CMD, DUMMY, WDATA, RDATA} state_e;
  state_e     state_q, state_d;
  logic [1:0] sck_sync_q, sck_sync_d, csn_sync_q, csn_sync_d;
  logic       sck_hist_q, sck_hist_d;
  logic [3:0] dq_sync1_q, dq_sync1_d, dq_sync2_q, dq_sync2_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d, tx_q, tx_d;
  logic       quad_q, quad_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] regs_q [16];
  logic [7:0] regs_d [16];
  logic       wr_evt_q, wr_evt_d;
  logic [3:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_dat_q, wr_dat_d;
  logic [3:0] dq_o_q, dq_o_d, dq_en_q, dq_en_d;
  logic       sck_s, csn_s, rise, fall, at_last, wr_byte, drive;
  logic [3:0] dq_s;
  logic [7:0] shift_in, tx_src;
  assign sck_sync_d = {sck_sync_q[0], qspi_sck_i};
  assign csn_sync_d = {csn_sync_q[0], qspi_csn_i};
  assign dq_sync1_d = {qspi_dq3_i, qspi_dq2_i, qspi_dq1_i, qspi_dq0_i};
  assign dq_sync2_d = dq_sync1_q;
  assign sck_s      = sck_sync_q[1];
  assign csn_s      = csn_sync_q[1];
  assign dq_s       = dq_sync2_q;
  assign sck_hist_d = sck_s;
  assign rise       = sck_s & ~sck_hist_q;
  assign fall       = ~sck_s & sck_hist_q;
  assign at_last    = cnt_q == (quad_q ? 4'd1 : 4'd7);
  assign shift_in   = quad_q ? {shift_q[3:0], dq_s} : {shift_q[6:0], dq_s[0]};
  // a count of zero marks a byte boundary: fetch the next register instead of shifting
  assign tx_src     = (cnt_q == 4'd0) ? regs_q[addr_q] : tx_q;
  assign wr_byte    = state_q == WDATA && !csn_s && rise && at_last;
  assign drive      = state_q == RDATA && !csn_s;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sck_sync_q <= '0;
      csn_sync_q <= 2'b11;
      sck_hist_q <= 1'b0;
      dq_sync1_q <= '0;
      dq_sync2_q <= '0;
      cnt_q      <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      quad_q     <= 1'b0;
      addr_q     <= '0;
      regs_q     <= '{default: '0};
      wr_evt_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_dat_q   <= '0;
      dq_o_q     <= '0;
      dq_en_q    <= '0;
    end else begin
      state_q    <= state_d;
      sck_sync_q <= sck_sync_d;
      csn_sync_q <= csn_sync_d;
      sck_hist_q <= sck_hist_d;
      dq_sync1_q <= dq_sync1_d;
      dq_sync2_q <= dq_sync2_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      quad_q     <= quad_d;
      addr_q     <= addr_d;
      regs_q     <= regs_d;
      wr_evt_q   <= wr_evt_d;
      wr_addr_q  <= wr_addr_d;
      wr_dat_q   <= wr_dat_d;
      dq_o_q     <= dq_o_d;
      dq_en_q    <= dq_en_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    quad_d  = quad_q;
    addr_d  = addr_q;
    if (state_q != IDLE && csn_s) state_d = IDLE;
    else begin
      case (state_q)
        IDLE: if (!csn_s) begin
          state_d = CMD;
          cnt_d   = '0;
          shift_d = '0;
          quad_d  = 1'b0;
        end
        CMD: if (rise) begin
          shift_d = {shift_q[6:0], dq_s[0]};
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d   = '0;
            shift_d = '0;
            quad_d  = shift_q[5];
            addr_d  = {shift_q[2:0], dq_s[0]};
            state_d = !shift_q[6] ? WDATA : (DUMMY_CYC == 0) ? RDATA : DUMMY;
          end
        end
        DUMMY: if (rise) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'(DUMMY_CYC - 1)) begin
            cnt_d   = '0;
            state_d = RDATA;
          end
        end
        WDATA: if (rise) begin
          shift_d = shift_in;
          cnt_d   = at_last ? 4'd0 : cnt_q + 4'd1;
          addr_d  = at_last ? addr_q + 4'd1 : addr_q;
        end
        RDATA: if (fall) begin
          tx_d   = quad_q ? {tx_src[3:0], 4'h0} : {tx_src[6:0], 1'b0};
          cnt_d  = at_last ? 4'd0 : cnt_q + 4'd1;
          addr_d = (cnt_q == 4'd0) ? addr_q + 4'd1 : addr_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_comb begin
    regs_d    = regs_q;
    wr_evt_d  = wr_byte;
    wr_addr_d = wr_byte ? addr_q : wr_addr_q;
    wr_dat_d  = wr_byte ? shift_in : wr_dat_q;
    if (wr_byte) regs_d[addr_q] = shift_in;
    dq_en_d   = !drive ? 4'h0 : fall ? (quad_q ? 4'hf : 4'h2) : dq_en_q;
    dq_o_d    = !drive ? 4'h0 : fall ? (quad_q ? tx_src[7:4] : {2'b00, tx_src[7], 1'b0}) : dq_o_q;
  end
  assign {qspi_dq3_o, qspi_dq2_o, qspi_dq1_o, qspi_dq0_o}     = dq_o_q;
  assign {qspi_dq3_en, qspi_dq2_en, qspi_dq1_en, qspi_dq0_en} = dq_en_q;
  assign reg_rd_dat = regs_q[reg_rd_addr];
  assign wr_evt     = wr_evt_q;
  assign wr_addr    = wr_addr_q;
  assign wr_dat     = wr_dat_q;
  assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_qspi_target.sv
// tb_qspi_target: directed table, hand sequences and random traffic against a register-array model
module tb_qspi_target;
  localparam int DUMMY = 4;
  logic clk = 1'b0, rst_n = 1'b0, sck = 1'b0, csn = 1'b1;
  logic [3:0] dq_in = 4'h0, reg_rd_addr = 4'h0;
  logic qspi_dq0_o, qspi_dq1_o, qspi_dq2_o, qspi_dq3_o;
  logic qspi_dq0_en, qspi_dq1_en, qspi_dq2_en, qspi_dq3_en;
  logic [7:0] reg_rd_dat, wr_dat;
  logic [3:0] wr_addr, en_w, out_w;
  logic wr_evt, busy;
  int n_chk = 0, n_fail = 0, cyc = 0, last_rise = 0;
  logic [7:0] mem [16];
  typedef struct { logic [3:0] a; logic [7:0] d; int lat; } ev_t;
  ev_t evq[$];
  typedef struct packed { logic [7:0] cmd; logic [1:0][7:0] d; logic [1:0][3:0] ea; } wvec_t;
  wvec_t wtab [3];
  qspi_target #(.DUMMY_CYC(DUMMY)) dut (
    .clk(clk), .rst_n(rst_n), .qspi_sck_i(sck), .qspi_csn_i(csn),
    .qspi_dq0_i(dq_in[0]), .qspi_dq1_i(dq_in[1]), .qspi_dq2_i(dq_in[2]), .qspi_dq3_i(dq_in[3]),
    .qspi_dq0_o(qspi_dq0_o), .qspi_dq1_o(qspi_dq1_o), .qspi_dq2_o(qspi_dq2_o), .qspi_dq3_o(qspi_dq3_o),
    .qspi_dq0_en(qspi_dq0_en), .qspi_dq1_en(qspi_dq1_en), .qspi_dq2_en(qspi_dq2_en), .qspi_dq3_en(qspi_dq3_en),
    .reg_rd_addr(reg_rd_addr), .reg_rd_dat(reg_rd_dat),
    .wr_evt(wr_evt), .wr_addr(wr_addr), .wr_dat(wr_dat), .busy(busy)
  );
  assign en_w  = {qspi_dq3_en, qspi_dq2_en, qspi_dq1_en, qspi_dq0_en};
  assign out_w = {qspi_dq3_o, qspi_dq2_o, qspi_dq1_o, qspi_dq0_o};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (wr_evt) evq.push_back('{wr_addr, wr_dat, cyc - last_rise});
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic pulse(input logic [3:0] din, output logic [3:0] dout, output logic [3:0] den);
    dq_in = din;
    repeat (6) @(negedge clk);
    dout = out_w;
    den  = en_w;
    sck = 1'b1;
    last_rise = cyc;
    repeat (6) @(negedge clk);
    sck = 1'b0;
  endtask
  task automatic send_cmd(input logic [7:0] cmd, output logic [3:0] en_acc);
    logic [3:0] o, e;
    en_acc = 4'h0;
    csn = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      pulse({3'b000, cmd[i]}, o, e);
      en_acc |= e;
    end
  endtask
  task automatic end_txn(input logic [3:0] en_before);
    repeat (6) @(negedge clk);
    csn = 1'b1;
    repeat (2) @(negedge clk);
    chk("busy_hold", busy, 1);
    chk("en_hold", en_w, en_before);
    @(negedge clk);
    chk("busy_drop", busy, 0);
    chk("en_drop", en_w, 0);
    repeat (4) @(negedge clk);
  endtask
  task automatic wr_txn(input logic [7:0] cmd, input logic [3:0][7:0] d, input logic [3:0][3:0] ea,
                        input int n, input int partial);
    logic [3:0] o, e, acc;
    evq.delete();
    send_cmd(cmd, acc);
    for (int i = 0; i < n; i++)
      if (cmd[6]) begin
        pulse(d[i][7:4], o, e);
        pulse(d[i][3:0], o, e);
      end else
        for (int b = 7; b >= 0; b--) pulse({3'b000, d[i][b]}, o, e);
    for (int j = 0; j < partial; j++) pulse(4'($urandom), o, e);
    end_txn(4'h0);
    chk("wr_cmd_en", acc, 0);
    chk("wr_count", evq.size(), n);
    for (int i = 0; i < n && i < evq.size(); i++) begin
      chk("wr_addr", evq[i].a, ea[i]);
      chk("wr_dat", evq[i].d, d[i]);
      chk("wr_lat", evq[i].lat, 3);
    end
    for (int i = 0; i < n; i++) mem[ea[i]] = d[i];
    for (int i = 0; i < n; i++) begin
      reg_rd_addr = ea[i];
      #1;
      chk("wr_readback", reg_rd_dat, mem[ea[i]]);
    end
  endtask
  task automatic rd_txn(input logic [7:0] cmd, input int n, input logic [3:0][7:0] exp);
    logic [3:0] o, e, acc, eor, eand, en_x;
    logic [7:0] got;
    en_x = cmd[6] ? 4'hf : 4'h2;
    send_cmd(cmd, acc);
    for (int i = 0; i < DUMMY; i++) begin
      pulse(4'h0, o, e);
      acc |= e;
    end
    chk("rd_pre_en", acc, 0);
    for (int i = 0; i < n; i++) begin
      got = 8'h00;
      eor = 4'h0;
      eand = 4'hf;
      for (int k = 0; k < (cmd[6] ? 2 : 8); k++) begin
        pulse(4'h0, o, e);
        got = cmd[6] ? {got[3:0], o} : {got[6:0], o[1]};
        eor |= e;
        eand &= e;
      end
      chk("rd_data", got, exp[i]);
      chk("rd_en", {eor, eand}, {en_x, en_x});
    end
    end_txn(en_x);
  endtask
  initial begin
    logic [7:0] cmd;
    logic [3:0] o, e, acc;
    logic [3:0][7:0] d;
    logic [3:0][3:0] ea;
    int n;
    wtab[0] = '{cmd: 8'h05, d: {8'h3C, 8'hA5}, ea: {4'h6, 4'h5}};
    wtab[1] = '{cmd: 8'h4F, d: {8'h34, 8'h12}, ea: {4'h0, 4'hF}};
    wtab[2] = '{cmd: 8'h33, d: {8'h99, 8'h81}, ea: {4'h4, 4'h3}};
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_wr_evt", wr_evt, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_dat", wr_dat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dq_o", out_w, 0);
    chk("rst_dq_en", en_w, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      reg_rd_addr = 4'(i);
      #1;
      chk("rst_reg", reg_rd_dat, 8'h00);
    end
    for (int i = 0; i < 3; i++) wr_txn(wtab[i].cmd, {16'h0, wtab[i].d}, {8'h0, wtab[i].ea}, 2, 0);
    reg_rd_addr = 4'd6;
    #1;
    chk("reg6", reg_rd_dat, 8'h3C);
    rd_txn(8'h83, 1, {24'h0, 8'h81});
    wr_txn(8'h42, {16'h0, 8'h5A, 8'hC7}, {8'h0, 4'h3, 4'h2}, 2, 0);
    rd_txn(8'hC2, 2, {16'h0, 8'h5A, 8'hC7});
    wr_txn(8'h01, 32'h0, 16'h0, 0, 5);
    reg_rd_addr = 4'd1;
    #1;
    chk("abort_reg1", reg_rd_dat, 8'h00);
    wr_txn(8'h01, {24'h0, 8'hFF}, {12'h0, 4'h1}, 1, 0);
    for (int t = 0; t < 24; t++) begin
      cmd = 8'($urandom);
      n = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) begin
        d[i]  = 8'($urandom);
        ea[i] = 4'((cmd[3:0] + i) % 16);
      end
      if (cmd[7]) begin
        for (int i = 0; i < 4; i++) d[i] = mem[ea[i]];
        rd_txn(cmd, n, d);
      end else wr_txn(cmd, d, ea, n, $urandom_range(0, cmd[6] ? 1 : 7));
    end
    send_cmd(8'hC2, acc);
    for (int i = 0; i < DUMMY + 3; i++) pulse(4'h0, o, e);
    repeat (6) @(negedge clk);
    chk("mid_en", en_w, 4'hf);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_en", en_w, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_dq", out_w, 0);
    csn = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      mem[i] = 8'h00;
      reg_rd_addr = 4'(i);
      #1;
      chk("rst_mid_reg", reg_rd_dat, mem[i]);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
